radix2_div_iter: RTL and testbench

- Iterative 32-bit divider controller for the execute-stage divide unit.
- Accepts one dividend/divisor pair, then runs 16 CALC cycles. Each cycle feeds 2 dividend bits plus the 31-bit partial remainder through one radix2_linediv step instance.
- Holds the quotient/remainder result until the downstream writeback consumes it.
- Sits between the execute issue logic (upstream) and the radix2_linediv step (instantiated inside).

---
 rtl/radix2_div_iter.sv | 232 +++++++++++++++++++++++
 tb/tb_radix2_div_iter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/radix2_div_iter.sv
// Iterative 32-bit radix-2 divider controller: 16 two-bit steps through one radix2_linediv.
// Signed support is compiled in only when MIST1032SA_DIV_SIGNED_EN is defined.

// One CALC iteration: two restoring-division bit steps on a 31-bit partial remainder.
module radix2_linediv (
    input  logic [1:0]  iSOURCE_DIVIDEND,
    input  logic [31:0] iSOURCE_DIVISOR,
    input  logic [30:0] iSOURCE_R,
    output logic [1:0]  oOUT_DATA_Q,
    output logic [30:0] oOUT_DATA_R
);
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [30:0] w_r1;
    logic        w_q1;
    logic        w_q0;

    always_comb begin
        w_t1        = {iSOURCE_R, iSOURCE_DIVIDEND[1]};
        w_q1        = (w_t1 >= iSOURCE_DIVISOR);
        w_r1        = w_q1 ? 31'(w_t1 - iSOURCE_DIVISOR) : w_t1[30:0];
        w_t2        = {w_r1, iSOURCE_DIVIDEND[0]};
        w_q0        = (w_t2 >= iSOURCE_DIVISOR);
        oOUT_DATA_R = w_q0 ? 31'(w_t2 - iSOURCE_DIVISOR) : w_t2[30:0];
        oOUT_DATA_Q = {w_q1, w_q0};
    end
endmodule

module radix2_div_iter #(
    parameter int unsigned P_CALC_CYCLES = 16
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iREMOVE,
    input  logic        iDATA_REQ,
    output logic        oDATA_BUSY,
    input  logic        iDATA_SIGN,
    input  logic [31:0] iDATA_DIVIDEND,
    input  logic [31:0] iDATA_DIVISOR,
    output logic        oDATA_VALID,
    input  logic        iDATA_BUSY,
    output logic [31:0] oDATA_Q,
    output logic [31:0] oDATA_R
);
    localparam int unsigned LP_CNT_W = 4;
    localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(P_CALC_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_OUT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LP_CNT_W-1:0] r_cnt;
    logic [30:0]         r_rem;
    logic [31:0]         r_shift;
    logic [31:0]         r_dvs;
    logic [31:0]         r_q;
    logic [31:0]         r_r;
    logic                r_valid;
    logic                r_busy;

    logic                w_sign_mode;
    logic                w_dvd_neg;
    logic                w_dvs_neg;
    logic [31:0]         w_dvd_mag;
    logic [31:0]         w_dvs_mag;
    logic                w_bp_ge;
    logic [31:0]         w_bp_q;
    logic [31:0]         w_bp_r;
    logic                w_start;
    logic                w_load_res;
    logic [31:0]         w_res_q;
    logic [31:0]         w_res_r;
    logic [1:0]          w_step_q;
    logic [30:0]         w_step_r;

`ifdef MIST1032SA_DIV_SIGNED_EN
    logic                r_signed;
    logic                r_qneg;
    logic                r_rneg;
    assign w_sign_mode = iDATA_SIGN;
`else
    logic                w_unused_sign;
    assign w_sign_mode   = 1'b0;
    assign w_unused_sign = iDATA_SIGN;
`endif

    assign w_dvd_neg = w_sign_mode & iDATA_DIVIDEND[31];
    assign w_dvs_neg = w_sign_mode & iDATA_DIVISOR[31];
    assign w_dvd_mag = w_dvd_neg ? 32'(-iDATA_DIVIDEND) : iDATA_DIVIDEND;
    assign w_dvs_mag = w_dvs_neg ? 32'(-iDATA_DIVISOR) : iDATA_DIVISOR;

    // Divisors >= 2^31 yield a quotient of 0 or 1, resolved by one compare with sign fix-up.
    always_comb begin
        w_bp_ge = (w_dvd_mag >= w_dvs_mag);
        w_bp_q  = {31'd0, w_bp_ge};
        w_bp_r  = w_bp_ge ? 32'(w_dvd_mag - w_dvs_mag) : w_dvd_mag;
        if (w_dvd_neg ^ w_dvs_neg) begin
            w_bp_q = 32'(-w_bp_q);
        end
        if (w_dvd_neg) begin
            w_bp_r = 32'(-w_bp_r);
        end
    end

    radix2_linediv u_step (
        .iSOURCE_DIVIDEND (r_shift[31:30]),
        .iSOURCE_DIVISOR  (r_dvs),
        .iSOURCE_R        (r_rem),
        .oOUT_DATA_Q      (w_step_q),
        .oOUT_DATA_R      (w_step_r)
    );

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load_res   = 1'b0;
        w_res_q      = r_q;
        w_res_r      = r_r;
        case (r_state)
            ST_IDLE: begin
                if (iDATA_REQ && !r_busy) begin
                    if (iDATA_DIVISOR == 32'd0) begin
                        w_load_res   = 1'b1;
                        w_res_q      = 32'hFFFF_FFFF;
                        w_res_r      = iDATA_DIVIDEND;
                        w_state_next = ST_OUT;
                    end else if (w_dvs_mag[31]) begin
                        w_load_res   = 1'b1;
                        w_res_q      = w_bp_q;
                        w_res_r      = w_bp_r;
                        w_state_next = ST_OUT;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (r_cnt == LP_LAST) begin
`ifdef MIST1032SA_DIV_SIGNED_EN
                    if (r_signed) begin
                        w_state_next = ST_FIX;
                    end else begin
                        w_load_res   = 1'b1;
                        w_res_q      = {r_shift[29:0], w_step_q};
                        w_res_r      = {1'b0, w_step_r};
                        w_state_next = ST_OUT;
                    end
`else
                    w_load_res   = 1'b1;
                    w_res_q      = {r_shift[29:0], w_step_q};
                    w_res_r      = {1'b0, w_step_r};
                    w_state_next = ST_OUT;
`endif
                end
            end
`ifdef MIST1032SA_DIV_SIGNED_EN
            ST_FIX: begin
                w_load_res   = 1'b1;
                w_res_q      = r_qneg ? 32'(-r_shift) : r_shift;
                w_res_r      = r_rneg ? 32'(-{1'b0, r_rem}) : {1'b0, r_rem};
                w_state_next = ST_OUT;
            end
`endif
            ST_OUT: begin
                if (!iDATA_BUSY) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Flush wins over acceptance and result consumption.
        if (iREMOVE) begin
            w_state_next = ST_IDLE;
            w_start      = 1'b0;
            w_load_res   = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_dvs   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef MIST1032SA_DIV_SIGNED_EN
            r_signed <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
`endif
        end else begin
            r_valid <= (w_state_next == ST_OUT);
            r_busy  <= (w_state_next != ST_IDLE);
            if (w_load_res) begin
                r_q <= w_res_q;
                r_r <= w_res_r;
            end
            if (w_start) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_shift <= w_dvd_mag;
                r_dvs   <= w_dvs_mag;
`ifdef MIST1032SA_DIV_SIGNED_EN
                r_signed <= w_sign_mode;
                r_qneg   <= w_dvd_neg ^ w_dvs_neg;
                r_rneg   <= w_dvd_neg;
`endif
            end else if (r_state == ST_CALC) begin
                r_cnt   <= r_cnt + LP_CNT_W'(1);
                r_rem   <= w_step_r;
                r_shift <= {r_shift[29:0], w_step_q};
            end
        end
    end

    assign oDATA_VALID = r_valid;
    assign oDATA_BUSY  = r_busy;
    assign oDATA_Q     = r_q;
    assign oDATA_R     = r_r;
endmodule

// File: tb/tb_radix2_div_iter.sv
// Self-checking bench for radix2_div_iter against a plain-arithmetic division model.
// Honours MIST1032SA_DIV_SIGNED_EN the same way as the design build.
module tb_radix2_div_iter;
`ifdef MIST1032SA_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        remove = 1'b0;
    logic        req = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dvd = '0;
    logic [31:0] dvs = '0;
    logic        ds_busy = 1'b0;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_q;
    logic [31:0] o_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    radix2_div_iter dut (
        .iCLOCK         (clk),
        .iRESET         (rst),
        .iREMOVE        (remove),
        .iDATA_REQ      (req),
        .oDATA_BUSY     (o_busy),
        .iDATA_SIGN     (sign),
        .iDATA_DIVIDEND (dvd),
        .iDATA_DIVISOR  (dvs),
        .oDATA_VALID    (o_valid),
        .iDATA_BUSY     (ds_busy),
        .oDATA_Q        (o_q),
        .oDATA_R        (o_r)
    );

    // Expected quotient/remainder and edges from accept to visible valid.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 0;
        end else if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            lat = (b == 32'h8000_0000) ? 0 : 17;
        end else begin
            q = a / b; r = a % b;
            lat = b[31] ? 0 : 16;
        end
    endtask

    // Present one request, then count edges until valid (bounded).
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int k, output bit busy_drop);
        @(negedge clk);
        req = 1'b1; dvd = a; dvs = b; sign = s;
        @(posedge clk); #1;
        req = 1'b0; dvd = $urandom; dvs = $urandom; sign = 1'($urandom);
        k = 0; busy_drop = 1'b0;
        while (!o_valid && k < 40) begin
            if (!o_busy) busy_drop = 1'b1;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_q !== 32'd0 || o_r !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b busy=%b q=%h r=%h required 0 0 0 0", o_valid, o_busy, o_q, o_r);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_ops(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
        logic [31:0] eq, er;
        int lat, k;
        bit bd;
        model(a, b, s, eq, er, lat);
        launch(a, b, s, k, bd);
        n_tests++;
        if (k !== lat || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s latency: %0d edges (valid=%b) required %0d", name, k, o_valid, lat);
        end
        n_tests++;
        if (o_q !== eq || o_r !== er) begin
            n_fail++;
            $display("FAIL %s result %h/%h s=%b: q=%h r=%h required q=%h r=%h", name, a, b, s, o_q, o_r, eq, er);
        end
        n_tests++;
        if (bd || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: dropped=%b busy=%b required held high", name, bd, o_busy);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s consume: valid=%b busy=%b required 0 0", name, o_valid, o_busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd100, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] tb [6] = '{32'd7, 32'd0, 32'h8000_0001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF};
        logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) test_ops(ta[i], tb[i], ts[i], $sformatf("directed%0d", i));
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'h8000_0000 | $urandom;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            test_ops(a, b, 1'($urandom), $sformatf("random%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int k;
        bit bd;
        ds_busy = 1'b1;
        launch(32'd1000, 32'd3, 1'b0, k, bd);
        req = 1'b1; dvd = 32'd50; dvs = 32'd5; sign = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_valid !== 1'b1 || o_q !== 32'd333 || o_r !== 32'd1) begin
                n_fail++;
                $display("FAIL hold%0d: valid=%b q=%0d r=%0d required 1 333 1", i, o_valid, o_q, o_r);
            end
        end
        ds_busy = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release: valid=%b busy=%b required 0 0", o_valid, o_busy);
        end
        @(posedge clk); #1;
        req = 1'b0;
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b accept: busy=%b required 1", o_busy);
        end
        k = 0;
        while (!o_valid && k < 40) begin @(posedge clk); #1; k++; end
        n_tests++;
        if (k !== 16 || o_q !== 32'd10 || o_r !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b result: edges=%0d q=%0d r=%0d required 16 10 0", k, o_q, o_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int k;
        bit bd, seen;
        @(negedge clk);
        req = 1'b1; dvd = 32'd12345; dvs = 32'd67; sign = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (8) @(posedge clk);
        #1 remove = 1'b1;
        @(posedge clk); #1;
        remove = 1'b0;
        n_tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush calc: busy=%b valid=%b required 0 0", o_busy, o_valid);
        end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (o_valid) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush novalid: valid seen=%b required 0", seen);
        end
        test_ops(32'd9, 32'd3, 1'b0, "post_flush");
        ds_busy = 1'b1;
        launch(32'd77, 32'd0, 1'b0, k, bd);
        remove = 1'b1;
        @(posedge clk); #1;
        remove = 1'b0; ds_busy = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush out: valid=%b busy=%b required 0 0", o_valid, o_busy);
        end
    endtask

    task automatic test_async_reset();
        test_ops(32'd9, 32'd3, 1'b0, "pre_reset");
        @(negedge clk);
        req = 1'b1; dvd = 32'd1000; dvs = 32'd7; sign = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_q !== 32'd0 || o_r !== 32'd0) begin
            n_fail++;
            $display("FAIL async reset: valid=%b busy=%b q=%h r=%h required 0 0 0 0", o_valid, o_busy, o_q, o_r);
        end
        @(negedge clk); rst = 1'b0;
        test_ops(32'd100, 32'd7, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
